// File: rtl/chan_arb_pkg.sv
// Shared types, constants and helpers for the channel arbiter and its round-robin picker.
package chan_arb_pkg;

  localparam int DATA_W = 8;
  localparam int CHAN_W = 2;
  localparam logic [CHAN_W-1:0] CHAN_INVALID = 2'd3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHAN_W-1:0] channel;
  } chan_txn_t;

  function automatic int rr_next(input int ptr, input int n);
    int nxt_s;
    if (ptr + 32'sd1 >= n) begin
      nxt_s = 32'sd0;
    end else begin
      nxt_s = ptr + 32'sd1;
    end
    return nxt_s;
  endfunction

endpackage

// File: rtl/chan_arbiter_checker.sv
// Protocol checks for the arbiter: requester hold rules, grant legality, output hold under backpressure.
module chan_arbiter_checker
  import chan_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic                      clk,
  input logic                      rst,
  input logic [N_REQ*DATA_W-1:0]   req_data,
  input logic [N_REQ*CHAN_W-1:0]   req_channel,
  input logic [N_REQ-1:0]          req_valid,
  input logic [N_REQ-1:0]          req_ready,
  input logic [DATA_W-1:0]         out_data,
  input logic [CHAN_W-1:0]         out_channel,
  input logic                      out_valid,
  input logic                      out_ready
);

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_req
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[gi] && !req_ready[gi]) |=>
        (req_valid[gi] && $stable(req_data[gi*DATA_W +: DATA_W]) &&
         $stable(req_channel[gi*CHAN_W +: CHAN_W])));
  end

  a_grant_legal: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready) && ((req_ready & ~req_valid) == {N_REQ{1'b0}}));

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_channel)));

endmodule

// File: rtl/chan_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  // Scan from the farthest slot back to rr_ptr so the nearest valid slot is written last.
  always_comb begin
    int sum_s;
    logic [IDX_W-1:0] idx_s;
    winner    = {IDX_W{1'b0}};
    any_valid = |req_valid;
    sum_s     = 32'sd0;
    idx_s     = {IDX_W{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum_s = int'(rr_ptr) + k;
      if (sum_s >= N_REQ) begin
        sum_s = sum_s - N_REQ;
      end else begin
        sum_s = sum_s;
      end
      idx_s = IDX_W'(sum_s);
      if (req_valid[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/chan_arbiter.sv
// Round-robin arbiter sharing one registered data/channel/valid/ready output among N_REQ drivers.
// Optional: CHAN_ARB_INVALID_DROP_EN consumes channel-3 transactions without forwarding them.
module chan_arbiter
  import chan_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*8-1:0]      req_data,
  input  logic [N_REQ*2-1:0]      req_channel,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  output logic [7:0]              out_data,
  output logic [1:0]              out_channel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N_REQ)-1:0] grant_id,
`ifdef CHAN_ARB_INVALID_DROP_EN
  output logic [CNT_W-1:0]        drop_cnt,
`endif
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic [0:0]       state_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] grant_r;
  chan_txn_t        out_txn_r;
  logic [CNT_W-1:0] xfer_cnt_r;
  logic [IDX_W-1:0] winner_s;
  logic             any_valid_s;
  logic             load_en_s;
  logic             accept_s;
  logic             consume_s;
  logic             drop_s;
  chan_txn_t        win_txn_s;

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Grant generation and winner field mux; nothing is granted while in reset.
  always_comb begin
    load_en_s = (state_r == ST_EMPTY) | out_ready;
    accept_s  = load_en_s & any_valid_s & ~rst;
    consume_s = (state_r == ST_FULL) & out_ready;
    req_ready = {N_REQ{1'b0}};
    win_txn_s = {(DATA_W + CHAN_W){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept_s & (winner_s == IDX_W'(i));
      if (winner_s == IDX_W'(i)) begin
        win_txn_s.data    = req_data[i*DATA_W +: DATA_W];
        win_txn_s.channel = req_channel[i*CHAN_W +: CHAN_W];
      end else begin
        win_txn_s = win_txn_s;
      end
    end
`ifdef CHAN_ARB_INVALID_DROP_EN
    drop_s = accept_s & (win_txn_s.channel == CHAN_INVALID);
`else
    drop_s = 1'b0;
`endif
  end

  // Output stage: load on a forwarded accept, otherwise drain when consumed; fields hold when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_EMPTY;
      out_txn_r <= {(DATA_W + CHAN_W){1'b0}};
      grant_r   <= {IDX_W{1'b0}};
    end else if (accept_s && !drop_s) begin
      state_r   <= ST_FULL;
      out_txn_r <= win_txn_s;
      grant_r   <= winner_s;
    end else if (consume_s) begin
      state_r   <= ST_EMPTY;
    end else begin
      state_r   <= state_r;
    end
  end

  // Round-robin pointer advances past every accepted requester, dropped or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      rr_ptr_r <= IDX_W'(rr_next(int'(winner_s), N_REQ));
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Completed-transfer counter, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_r <= {CNT_W{1'b0}};
    end else if (consume_s) begin
      xfer_cnt_r <= xfer_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

`ifdef CHAN_ARB_INVALID_DROP_EN
  logic [CNT_W-1:0] drop_cnt_r;

  // Dropped-transaction counter, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (drop_s) begin
      drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  assign out_valid   = (state_r == ST_FULL);
  assign out_data    = out_txn_r.data;
  assign out_channel = out_txn_r.channel;
  assign grant_id    = grant_r;
  assign xfer_cnt    = xfer_cnt_r;

  chan_arbiter_checker #(.N_REQ(N_REQ)) u_checker (
    .clk         (clk),
    .rst         (rst),
    .req_data    (req_data),
    .req_channel (req_channel),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

endmodule

// File: doc/chan_arbiter.md
Name: chan_arbiter

Overview:
- Shares the single data/channel_id/valid/ready input of the channel-routing proxy between N_REQ independent drivers.
- Round-robin arbitration, one transaction per grant; output is a registered stage with full throughput under backpressure.
- Sits between the driver instances and the proxy in the combinational-DUT testbench top.
- Also keeps a wrapping transfer counter for the bench scoreboard.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 16, width of xfer_cnt.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_data  in  N_REQ*8  requester i data at [i*8+:8]
- req_channel  in  N_REQ*2  requester i channel_id at [i*2+:2]
- req_valid  in  N_REQ  requester i has a transaction
- req_ready  out  N_REQ  one-hot grant/accept; transfer on req_valid[i]&req_ready[i]
- out_data  out  8  to proxy data
- out_channel  out  2  to proxy channel_id
- out_valid  out  1  to proxy valid
- out_ready  in  1  from proxy ready
- grant_id  out  $clog2(N_REQ)  index of requester whose transaction is in the output stage
- xfer_cnt  out  CNT_W  count of transactions completed on the output (out_valid&out_ready)

Behaviour:
- Reset (async assert, sync deassert by clk): out_valid=0, out_data=0, out_channel=0, grant_id=0, xfer_cnt=0, rr_ptr=0. req_ready is all-zero while rst is high.
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = EMPTY | (FULL & out_ready).
- Arbitration is combinational:
  - Winner w = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready = onehot(w) when load_en and any req_valid; otherwise 0.
  - req_ready never asserts for a requester whose valid is low.
- On accept of w:
  - out_data/out_channel <= requester w's fields; grant_id <= w; out_valid <= 1.
  - rr_ptr <= (w+1) mod N_REQ.
- Latency: accept at edge k gives out_valid=1 from edge k to k+1.
- Throughput: back-to-back accepts allowed, 1 per cycle while out_ready=1.
- Output consumed and no request: FULL -> EMPTY, out_valid <= 0; data/channel/grant_id hold their last values.
- Backpressure: FULL & !out_ready keeps out_data, out_channel and grant_id stable, and req_ready=0.
- No-request cycles leave rr_ptr unchanged.
- xfer_cnt increments on every out_valid&out_ready and wraps 2^CNT_W-1 -> 0.
- Channel ID is not interpreted; value 3 is forwarded unchanged (see optional feature).
- Reset mid-transaction drops any held output transaction; requesters must re-present.
- Requester rules (checked by assertion, not by RTL): data and channel stay stable while valid=1 and ready=0; valid is not withdrawn before the transfer.

Optional Feature:
- Macro: CHAN_ARB_INVALID_DROP_EN.
- Defined:
  - A transaction whose channel==3 is accepted (req_ready asserts normally) and consumed, but never loaded into the output stage.
  - out_valid is not raised and rr_ptr still advances.
  - Adds output drop_cnt [CNT_W], reset 0, incremented per dropped transaction, wrapping.
- Undefined: channel 3 is forwarded like any other; no drop_cnt port.

Decomposition:
- Package chan_arb_pkg:
  - DATA_W=8, CHAN_W=2, CHAN_INVALID=2'd3.
  - typedef struct packed {logic [DATA_W-1:0] data; logic [CHAN_W-1:0] channel;} chan_txn_t.
  - Function rr_next(ptr, n).
- Sub-module rr_picker (combinational): inputs req_valid and rr_ptr; outputs winner index and any_valid. Reused later for proxy-side port arbitration.

Test Plan:
- Single requester 0 sends data=10, ch=0 with out_ready=1 -> out_valid for 1 cycle, out_data=10, out_channel=0, grant_id=0; xfer_cnt=1.
- All 4 requesters valid continuously (data 10/20/30/40) with out_ready=1 -> grants in order 0,1,2,3,0,...; one out_valid per cycle; no gaps.
- out_ready low for 5 cycles while FULL holding data=20, ch=1 -> outputs stable; req_ready=0 throughout; data=20 delivered once after release.
- Requesters 1 and 3 valid, rr_ptr=2 -> 3 wins first, then 1; requesters 0 and 2 are never granted.
- Assert rst while FULL with data=30 -> out_valid=0 and xfer_cnt=0 immediately, without waiting for a clock edge; after release, rr_ptr=0 and requester 0 wins first.
- Requester sends data=40, ch=3:
  - With CHAN_ARB_INVALID_DROP_EN: accepted, no out_valid, drop_cnt=1.
  - Without it: forwarded with out_channel=3.
